// File: rtl/wait_state_ram.sv
// Synchronous RAM with a request/ready handshake, programmable wait states,
// an optional write-protected upper window and a post-reset fill sequencer.
module wait_state_ram #(
  parameter int                      ADDR_WIDTH     = 16,
  parameter int                      DATA_WIDTH     = 8,
  parameter int                      WAIT_STATES    = 0,
  parameter bit                      ROM_ENABLE     = 1'b0,
  parameter logic [ADDR_WIDTH-1:0]   ROM_BASE       = 16'hE000,
  parameter bit                      CLEAR_ON_RESET = 1'b0,
  parameter logic [DATA_WIDTH-1:0]   FILL_VALUE     = 8'h00
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  RDY,
  output logic                  BUSY,
  output logic                  WP_FAULT
);

  localparam int          DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   fill_cnt_q, fill_cnt_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rdy_q, rdy_d;
  logic                  wpf_q, wpf_d;
  logic                  busy_q, busy_d;

  logic                  acc_en;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_din;
  logic                  acc_blocked;
  logic                  fill_we;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    dout_d     = dout_q;
    rdy_d      = 1'b0;
    wpf_d      = 1'b0;
    busy_d     = busy_q;
    acc_en     = 1'b0;
    acc_we     = we_q;
    acc_addr   = addr_q;
    acc_din    = din_q;
    fill_we    = 1'b0;

    case (state_q)
      S_FILL: begin
        if (CLEAR_ON_RESET) begin
          fill_we    = 1'b1;
          fill_cnt_d = fill_cnt_q + 1'b1;
          // MSB of the counter sets once the top address has been written
          if (fill_cnt_d[ADDR_WIDTH]) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_IDLE: begin
        if (REQ) begin
          we_d       = WE;
          addr_d     = Address;
          din_d      = DataIn;
          wait_cnt_d = WS;
          if (WS == 4'd0) begin
            acc_en   = 1'b1;
            acc_we   = WE;
            acc_addr = Address;
            acc_din  = DataIn;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 1'b1;
        if (wait_cnt_q == 4'd1) begin
          acc_en  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_FILL;
    endcase

    acc_blocked = ROM_ENABLE && acc_we && (acc_addr >= ROM_BASE);
    if (acc_en) begin
      dout_d = mem[acc_addr];
      rdy_d  = 1'b1;
      wpf_d  = acc_blocked;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_FILL;
      fill_cnt_q <= '0;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      dout_q     <= '0;
      rdy_q      <= 1'b0;
      wpf_q      <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      dout_q     <= dout_d;
      rdy_q      <= rdy_d;
      wpf_q      <= wpf_d;
      busy_q     <= busy_d;
    end
  end

  // Contents are deliberately not reset; fill writes are held off while RST is high
  always_ff @(posedge CLK) begin
    if (fill_we && !RST) begin
      mem[fill_cnt_q[ADDR_WIDTH-1:0]] <= FILL_VALUE;
    end else if (acc_en && acc_we && !acc_blocked) begin
      mem[acc_addr] <= acc_din;
    end
  end

  assign DataOut  = dout_q;
  assign RDY      = rdy_q;
  assign BUSY     = busy_q;
  assign WP_FAULT = wpf_q;

endmodule

// File: tb/tb_wait_state_ram.sv
// Scoreboard bench: one instance with no wait states and a protected window,
// one with three wait states; a monitor per instance checks every RDY pulse.
module tb_wait_state_ram;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       wpf;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;

  logic       rst0, req0, we0, rdy0, busy0, wpf0;
  logic [7:0] a0, di0, do0;
  logic       rst3, req3, we3, rdy3, busy3, wpf3;
  logic [7:0] a3, di3, do3;
  int         n;

  wait_state_ram #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(0),
    .ROM_ENABLE(1'b1), .ROM_BASE(8'hE0),
    .CLEAR_ON_RESET(1'b1), .FILL_VALUE(8'h5A)
  ) u0 (
    .CLK(CLK), .RST(rst0), .REQ(req0), .WE(we0), .Address(a0), .DataIn(di0),
    .DataOut(do0), .RDY(rdy0), .BUSY(busy0), .WP_FAULT(wpf0)
  );

  wait_state_ram #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(3),
    .ROM_ENABLE(1'b0), .ROM_BASE(8'hE0),
    .CLEAR_ON_RESET(1'b1), .FILL_VALUE(8'h5A)
  ) u3 (
    .CLK(CLK), .RST(rst3), .REQ(req3), .WE(we3), .Address(a3), .DataIn(di3),
    .DataOut(do3), .RDY(rdy3), .BUSY(busy3), .WP_FAULT(wpf3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (rdy0) begin
      if (q0.size() == 0) begin
        check("u0_unexpected_rdy", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        check("u0_dataout", {24'd0, do0}, {24'd0, e0.data});
        check("u0_wp_fault", {31'd0, wpf0}, {31'd0, e0.wpf});
      end
    end else if (wpf0) begin
      check("u0_wpf_without_rdy", {31'd0, wpf0}, 32'd0);
    end
    if (busy0 && (rdy0 || wpf0)) check("u0_out_while_busy", {30'd0, rdy0, wpf0}, 32'd0);
  end

  always @(negedge CLK) begin
    if (rdy3) begin
      if (q3.size() == 0) begin
        check("u3_unexpected_rdy", 32'd1, 32'd0);
      end else begin
        e3 = q3.pop_front();
        check("u3_dataout", {24'd0, do3}, {24'd0, e3.data});
        check("u3_wp_fault", {31'd0, wpf3}, {31'd0, e3.wpf});
      end
    end else if (wpf3) begin
      check("u3_wpf_without_rdy", {31'd0, wpf3}, 32'd0);
    end
    if (busy3 && (rdy3 || wpf3)) check("u3_out_while_busy", {30'd0, rdy3, wpf3}, 32'd0);
  end

  // Called at a negedge; leaves REQ high so consecutive calls are back-to-back.
  task automatic issue0(input logic we, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_d, input logic exp_w);
    req0 = 1'b1; we0 = we; a0 = a; di0 = d;
    q0.push_back('{data: exp_d, wpf: exp_w});
    @(posedge CLK); @(negedge CLK);
    check("u0_rdy_next_cycle", {31'd0, rdy0}, 32'd1);
  endtask

  task automatic issue3(input logic we, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_d);
    req3 = 1'b1; we3 = we; a3 = a; di3 = d;
    q3.push_back('{data: exp_d, wpf: 1'b0});
    @(posedge CLK); @(negedge CLK);
    req3 = 1'b0;
    repeat (2) begin @(posedge CLK); @(negedge CLK); end
    check("u3_rdy_before_access", {31'd0, rdy3}, 32'd0);
    @(posedge CLK); @(negedge CLK);
    check("u3_rdy_after_access", {31'd0, rdy3}, 32'd1);
  endtask

  task automatic count_busy3(output int cyc);
    cyc = 0;
    while (busy3 && cyc < 1000) begin
      @(posedge CLK); @(negedge CLK);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; a0 = 8'h00; di0 = 8'h00;
    rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; a3 = 8'h00; di3 = 8'h00;
    repeat (3) @(negedge CLK);
    check("u0_reset_busy", {31'd0, busy0}, 32'd1);
    check("u0_reset_dataout", {24'd0, do0}, 32'd0);
    check("u0_reset_rdy", {30'd0, rdy0, wpf0}, 32'd0);

    // REQ held throughout the fill must not complete until BUSY falls
    req0 = 1'b1; we0 = 1'b0; a0 = 8'h00;
    rst0 = 1'b0; rst3 = 1'b0;
    n = 0;
    while (busy0 && n < 1000) begin
      @(posedge CLK); @(negedge CLK);
      n++;
    end
    check("u0_fill_cycles", n, 256);
    check("u0_dataout_after_fill", {24'd0, do0}, 32'd0);

    issue0(1'b0, 8'h00, 8'h00, 8'h5A, 1'b0);
    issue0(1'b0, 8'h7F, 8'h00, 8'h5A, 1'b0);
    issue0(1'b0, 8'hFF, 8'h00, 8'h5A, 1'b0);
    issue0(1'b1, 8'h10, 8'hAB, 8'h5A, 1'b0);
    issue0(1'b0, 8'h10, 8'h00, 8'hAB, 1'b0);
    req0 = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("u0_rdy_idle", {31'd0, rdy0}, 32'd0);

    issue0(1'b1, 8'hE5, 8'h11, 8'h5A, 1'b1);
    issue0(1'b0, 8'hE5, 8'h00, 8'h5A, 1'b0);
    issue0(1'b1, 8'hE0, 8'h33, 8'h5A, 1'b1);
    issue0(1'b0, 8'hE0, 8'h00, 8'h5A, 1'b0);
    issue0(1'b1, 8'hDF, 8'h22, 8'h5A, 1'b0);
    issue0(1'b0, 8'hDF, 8'h00, 8'h22, 1'b0);
    req0 = 1'b0;
    @(posedge CLK); @(negedge CLK);

    count_busy3(n);
    check("u3_idle_ready", {31'd0, busy3}, 32'd0);

    // Read with three wait states while REQ/WE/Address toggle during WAIT
    req3 = 1'b1; we3 = 1'b0; a3 = 8'h40;
    q3.push_back('{data: 8'h5A, wpf: 1'b0});
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); @(negedge CLK);
      check("u3_rdy_timing", {31'd0, rdy3}, (k == 3) ? 32'd1 : 32'd0);
      req3 = (k < 3) ? ~req3 : 1'b0;
      we3  = 1'b1;
      a3   = 8'(k);
      di3  = 8'hFF;
    end

    issue3(1'b1, 8'h40, 8'h77, 8'h5A);
    issue3(1'b0, 8'h40, 8'h00, 8'h77);

    // Reset lands in the WAIT state of a write to 8'h20
    req3 = 1'b1; we3 = 1'b1; a3 = 8'h20; di3 = 8'h99;
    @(posedge CLK); @(negedge CLK);
    req3 = 1'b0;
    @(posedge CLK);
    #2 rst3 = 1'b1;
    #1;
    check("u3_rst_busy", {31'd0, busy3}, 32'd1);
    check("u3_rst_dataout", {24'd0, do3}, 32'd0);
    check("u3_rst_rdy", {31'd0, rdy3}, 32'd0);
    @(posedge CLK); @(negedge CLK);
    rst3 = 1'b0;
    count_busy3(n);
    check("u3_refill_cycles", n, 256);
    issue3(1'b0, 8'h20, 8'h00, 8'h5A);
    issue3(1'b0, 8'h40, 8'h00, 8'h5A);

    repeat (3) @(negedge CLK);
    check("u0_queue_drained", q0.size(), 32'd0);
    check("u3_queue_drained", q3.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
